// File: rtl/booth_divider.sv
// Signed restoring divider: a 2*size-bit dividend divided by a size-bit divisor,
// producing a quotient and remainder truncated toward zero.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   start        begin a division (sampled only while idle)
//   dividend     2*size-bit two's-complement numerator
//   divisor      size-bit two's-complement denominator
//   quotient     registered signed quotient (0 on error)
//   remainder    registered signed remainder, sign of dividend (0 on error)
//   busy         high in every state except IDLE
//   done         one-cycle completion pulse
//   div_by_zero  divisor was zero
//   overflow     quotient does not fit in size signed bits
//
// state | meaning
// IDLE  | waiting for start; results hold
// LOAD  | form magnitudes and signs, early error checks
// RUN   | size shift-subtract iterations, one quotient bit per clock
// FIX   | apply signs, final range check, register results
// DONE  | done pulse for one cycle
module booth_divider #(
    parameter int size = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [2*size-1:0]   dividend,
    input  logic [size-1:0]     divisor,
    output logic [size-1:0]     quotient,
    output logic [size-1:0]     remainder,
    output logic                busy,
    output logic                done,
    output logic                div_by_zero,
    output logic                overflow
);

    localparam int CW = $clog2(size + 1);
    localparam logic [size-1:0] HALF = {1'b1, {(size-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD, RUN, FIX, DONE} state_t;

    state_t              state_q;
    logic [2*size-1:0]   dd_q;
    logic [size-1:0]     dv_q;
    logic [size-1:0]     dvm_q;
    logic [size-1:0]     rem_q;
    logic [size-1:0]     acc_q;
    logic                sdd_q;
    logic                sdv_q;
    logic [CW-1:0]       cnt_q;
    logic [size-1:0]     quotient_q;
    logic [size-1:0]     remainder_q;
    logic                busy_q;
    logic                done_q;
    logic                dbz_q;
    logic                ovf_q;

    logic [2*size-1:0]   mag_dd_d;
    logic [size-1:0]     mag_dv_d;
    logic                load_ovf_d;
    logic [size:0]       trial_d;
    logic                fits_d;
    logic [size-1:0]     rem_d;
    logic [size-1:0]     acc_d;
    logic                qneg_d;
    logic                fix_ovf_d;
    logic [size-1:0]     q_fix_d;
    logic [size-1:0]     r_fix_d;

    // Negating the most negative dividend yields the correct unsigned magnitude
    // because the magnitude is kept at the full 2*size width.
    assign mag_dd_d   = dd_q[2*size-1] ? -dd_q : dd_q;
    assign mag_dv_d   = dv_q[size-1]   ? -dv_q : dv_q;
    // Upper half >= divisor means the quotient needs more than size bits.
    assign load_ovf_d = mag_dd_d[2*size-1:size] >= mag_dv_d;

    // Partial remainder always stays below the divisor, so the difference
    // fits in size bits and the top bit of the trial can be dropped.
    assign trial_d = {rem_q, acc_q[size-1]};
    assign fits_d  = trial_d >= {1'b0, dvm_q};
    assign rem_d   = fits_d ? (trial_d[size-1:0] - dvm_q) : trial_d[size-1:0];
    assign acc_d   = {acc_q[size-2:0], fits_d};

    assign qneg_d    = sdd_q ^ sdv_q;
    // A negative quotient may reach magnitude 2^(size-1); a positive one may not.
    assign fix_ovf_d = qneg_d ? (acc_q > HALF) : acc_q[size-1];
    assign q_fix_d   = qneg_d ? -acc_q : acc_q;
    assign r_fix_d   = sdd_q  ? -rem_q : rem_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            dd_q        <= '0;
            dv_q        <= '0;
            dvm_q       <= '0;
            rem_q       <= '0;
            acc_q       <= '0;
            sdd_q       <= 1'b0;
            sdv_q       <= 1'b0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dd_q        <= dividend;
                        dv_q        <= divisor;
                        quotient_q  <= '0;
                        remainder_q <= '0;
                        dbz_q       <= 1'b0;
                        ovf_q       <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= LOAD;
                    end
                end
                LOAD: begin
                    sdd_q <= dd_q[2*size-1];
                    sdv_q <= dv_q[size-1];
                    rem_q <= mag_dd_d[2*size-1:size];
                    acc_q <= mag_dd_d[size-1:0];
                    dvm_q <= mag_dv_d;
                    cnt_q <= '0;
                    if (dv_q == '0) begin
                        dbz_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (load_ovf_d) begin
                        ovf_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    rem_q <= rem_d;
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(size - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    // Results were cleared on start, so an overflow leaves them 0.
                    if (fix_ovf_d) begin
                        ovf_q <= 1'b1;
                    end else begin
                        quotient_q  <= q_fix_d;
                        remainder_q <= r_fix_d;
                    end
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_booth_divider.sv
module tb_booth_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic        overflow;

    booth_divider #(.size(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        logic       ovf;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    always @(posedge clk) begin
        #1;
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] dd, input logic [7:0] dv);
        exp_t m;
        int a, b, aa, ab, q, r;
        m = '{8'h00, 8'h00, 1'b0, 1'b0, 11};
        a = int'($signed(dd));
        b = int'($signed(dv));
        if (b == 0) begin
            m.dbz = 1'b1;
            m.lat = 2;
        end else begin
            aa = (a < 0) ? -a : a;
            ab = (b < 0) ? -b : b;
            if (aa / ab >= 256) begin
                m.ovf = 1'b1;
                m.lat = 2;
            end else begin
                q = a / b;
                r = a % b;
                if (q > 127 || q < -128) begin
                    m.ovf = 1'b1;
                end else begin
                    m.q = q[7:0];
                    m.r = r[7:0];
                end
            end
        end
        return m;
    endfunction

    // Called away from a clock edge with the DUT idle; returns at posedge+1.
    task automatic run(input logic [15:0] dd, input logic [7:0] dv,
                       input logic [7:0] eq, input logic [7:0] er,
                       input logic edbz, input logic eovf, input int elat,
                       input bit poke);
        exp_t e;
        int   edges;
        int   dc0;
        e = '{eq, er, edbz, eovf, elat};
        sb.push_back(e);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        dc0      = done_cnt;
        @(posedge clk);
        #1;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("clear_on_start", 32'({quotient, remainder, div_by_zero, overflow}), 32'd0);
        start    = 1'b0;
        dividend = ~dd;
        divisor  = dv + 8'd3;
        edges    = 1;
        while (edges < 40) begin
            @(posedge clk);
            edges++;
            #1;
            if (poke && edges == 4) start = 1'b1;
            if (poke && edges == 6) start = 1'b0;
            if (done === 1'b1) break;
        end
        e = sb.pop_front();
        chk("done_seen", 32'(done), 32'd1);
        chk("latency", edges, e.lat);
        chk("quotient", 32'(quotient), 32'(e.q));
        chk("remainder", 32'(remainder), 32'(e.r));
        chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
        chk("overflow", 32'(overflow), 32'(e.ovf));
        @(posedge clk);
        #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_not_busy", 32'(busy), 32'd0);
        chk("hold_result", 32'({quotient, remainder, div_by_zero, overflow}),
            32'({e.q, e.r, e.dbz, e.ovf}));
        chk("done_count", done_cnt - dc0, 32'd1);
    endtask

    initial begin
        logic [15:0] rdd;
        logic [7:0]  rdv;
        exp_t        m;
        int          dc0;

        #2 rst = 1'b0;
        #1;
        chk("reset_outputs", 32'({quotient, remainder, busy, done, div_by_zero, overflow}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        run(16'd100,  8'd7,   8'd14,  8'd2,   1'b0, 1'b0, 11, 1'b0);
        run(16'hFF9C, 8'd7,   8'hF2,  8'hFE,  1'b0, 1'b0, 11, 1'b0);
        run(16'd100,  8'hF9,  8'hF2,  8'h02,  1'b0, 1'b0, 11, 1'b0);
        run(16'hFF80, 8'd1,   8'h80,  8'h00,  1'b0, 1'b0, 11, 1'b0);
        run(16'h0080, 8'd1,   8'h00,  8'h00,  1'b0, 1'b1, 11, 1'b0);
        run(16'h4000, 8'h01,  8'h00,  8'h00,  1'b0, 1'b1, 2,  1'b0);
        run(16'd5,    8'h00,  8'h00,  8'h00,  1'b1, 1'b0, 2,  1'b0);
        run(16'd100,  8'd7,   8'd14,  8'd2,   1'b0, 1'b0, 11, 1'b1);
        run(16'h8000, 8'h80,  8'h00,  8'h00,  1'b0, 1'b1, 2,  1'b0);
        run(16'hFFFF, 8'hFF,  8'h01,  8'h00,  1'b0, 1'b0, 11, 1'b0);

        for (int i = 0; i < 24; i++) begin
            rdd = 16'($urandom);
            rdd = $signed(rdd) >>> $urandom_range(0, 12);
            rdv = 8'($urandom);
            if ($urandom_range(0, 7) == 0) rdv = 8'h00;
            m = model(rdd, rdv);
            run(rdd, rdv, m.q, m.r, m.dbz, m.ovf, m.lat, 1'b0);
        end

        // Reset in the middle of RUN: outputs drop without a clock, no done.
        dividend = 16'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dc0   = done_cnt;
        repeat (3) @(posedge clk);
        #2;
        chk("busy_before_reset", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_async", 32'({quotient, remainder, busy, done, div_by_zero, overflow}), 32'd0);
        repeat (14) @(posedge clk);
        #1;
        chk("rst_held", 32'({quotient, remainder, busy, done, div_by_zero, overflow}), 32'd0);
        chk("rst_no_done", done_cnt - dc0, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run(16'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0, 11, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
